// File: rtl/led_pattern_ctrl_pkg.sv
// rtl/led_pattern_ctrl_pkg.sv - shared mode/direction encodings and LED seeds for the run-light
package led_pattern_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN_R  = 2'd0,
    MODE_RUN_L  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [3:0] SEED_RUN   = 4'b1110;
  localparam logic [3:0] SEED_BLINK = 4'b1111;

  function automatic logic [3:0] mode_seed(input mode_t m);
    return (m == MODE_BLINK) ? SEED_BLINK : SEED_RUN;
  endfunction

endpackage

// File: rtl/led_pattern_ctrl_tick_gen.sv
// rtl/led_pattern_ctrl_tick_gen.sv - step timer: period BASE_CNT>>speed, pause hold, button clear
module led_tick_gen #(
  parameter int BASE_CNT = 500_000,
  localparam int TW = $clog2(BASE_CNT)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       clear,
  output logic       tick
);

  logic [TW-1:0] timer;
  logic [TW-1:0] last;

  always_comb begin
    last = TW'((BASE_CNT >> speed) - 1);
    // a button press in the final count cycle pre-empts the step
    tick = (timer == last) && !pause && !clear;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (clear || tick) begin
      timer <= '0;
    end else if (!pause) begin
      timer <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - 4-LED run-light sequencer: mode/speed/dir registers and LED step mux
module led_pattern_ctrl
  import led_pattern_ctrl_pkg::*;
#(
  parameter int LED_W    = 4,
  parameter int BASE_CNT = 500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_mode,
  input  logic             btn_speed,
  input  logic             pause,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic [1:0]       speed,
  output logic             tick
);

  mode_t            mode_q, mode_d;
  dir_t             dir_q, dir_d;
  logic [1:0]       speed_q, speed_d;
  logic [LED_W-1:0] led_q, led_d;

  led_tick_gen #(.BASE_CNT(BASE_CNT)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .speed (speed_q),
    .pause (pause),
    .clear (btn_mode | btn_speed),
    .tick  (tick)
  );

  always_comb begin
    mode_d  = mode_q;
    dir_d   = dir_q;
    speed_d = speed_q;
    led_d   = led_q;
    if (btn_mode) begin
      mode_d = mode_t'(mode_q + 2'd1);
      dir_d  = DIR_LEFT;
      led_d  = mode_seed(mode_d);
    end
    if (btn_speed) begin
      speed_d = speed_q + 2'd1;
    end
    // tick is already gated off by either button, so these never collide
    if (tick) begin
      case (mode_q)
        MODE_RUN_R: led_d = {led_q[0], led_q[3:1]};
        MODE_RUN_L: led_d = {led_q[2:0], led_q[3]};
        MODE_BOUNCE: begin
          if (dir_q == DIR_LEFT) begin
            if (!led_q[3]) begin
              dir_d = DIR_RIGHT;
              led_d = {1'b1, led_q[3:1]};
            end else begin
              led_d = {led_q[2:0], 1'b1};
            end
          end else begin
            if (!led_q[0]) begin
              dir_d = DIR_LEFT;
              led_d = {led_q[2:0], 1'b1};
            end else begin
              led_d = {1'b1, led_q[3:1]};
            end
          end
        end
        default: led_d = ~led_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_RUN_R;
      dir_q   <= DIR_LEFT;
      speed_q <= 2'd0;
      led_q   <= SEED_RUN;
    end else begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      speed_q <= speed_d;
      led_q   <= led_d;
    end
  end

  assign led   = led_q;
  assign mode  = mode_q;
  assign speed = speed_q;

endmodule
